// File: rtl/psw_pkg.sv
// Shared PSW definitions: flag bit positions, branch condition codes and the
// branch unit FSM encoding. Also imported by the ALU flag block.
package psw_pkg;

    localparam int PSW_CY = 7;
    localparam int PSW_AC = 6;
    localparam int PSW_OV = 2;
    localparam int PSW_P  = 0;

    typedef enum logic [2:0] {
        COND_JC   = 3'd0,
        COND_JNC  = 3'd1,
        COND_JZ   = 3'd2,
        COND_JNZ  = 3'd3,
        COND_JOV  = 3'd4,
        COND_JNOV = 3'd5,
        COND_JAC  = 3'd6,
        COND_SJMP = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Only the flags that a branch condition can test.
    typedef struct packed {
        logic cy;
        logic ac;
        logic ov;
    } cond_flags_t;

    function automatic cond_flags_t get_cond_flags(input logic [7:0] psw);
        cond_flags_t f;
        f.cy = psw[PSW_CY];
        f.ac = psw[PSW_AC];
        f.ov = psw[PSW_OV];
        return f;
    endfunction

endpackage

// File: rtl/psw_branch_unit_if.sv
// Request/response channel of the PSW branch unit: one valid/ready request
// carrying the branch operands and one valid/ready response with the result.
interface psw_branch_unit_if #(
    parameter int PC_W = 16
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      cond;
    logic [PC_W-1:0] pc_in;
    logic [7:0]      rel;
    logic [7:0]      acc_in;
    logic            resp_valid;
    logic            resp_ready;
    logic            taken;
    logic [PC_W-1:0] target_pc;

    modport master (
        output req_valid, cond, pc_in, rel, acc_in, resp_ready,
        input  req_ready, resp_valid, taken, target_pc
    );

    modport slave (
        input  req_valid, cond, pc_in, rel, acc_in, resp_ready,
        output req_ready, resp_valid, taken, target_pc
    );
endinterface

// File: rtl/psw_cond_eval.sv
// Combinational 8051 branch condition evaluator: flags snapshot, accumulator
// and condition code in, taken out.
module psw_cond_eval
    import psw_pkg::*;
(
    input  cond_flags_t flags_i,
    input  logic [7:0]  acc_i,
    input  cond_e       cond_i,
    output logic        taken_o
);

    // NOTE: assign a default before the case so no path leaves taken_o
    // unassigned, otherwise synthesis infers a latch.
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_JC:   taken_o = flags_i.cy;
            COND_JNC:  taken_o = ~flags_i.cy;
            COND_JZ:   taken_o = (acc_i == 8'h00);
            COND_JNZ:  taken_o = (acc_i != 8'h00);
            COND_JOV:  taken_o = flags_i.ov;
            COND_JNOV: taken_o = ~flags_i.ov;
            COND_JAC:  taken_o = flags_i.ac;
            COND_SJMP: taken_o = 1'b1;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/psw_branch_unit.sv
// Resolves 8051-style conditional relative jumps against a shadow PSW.
// One request in flight: IDLE accepts, EVAL resolves, RESP holds the result.
module psw_branch_unit
    import psw_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    psw_branch_unit_if.slave bus,
    input  logic [7:0]       psw_in,
    input  logic             psw_load,
    output logic [7:0]       psw_shadow,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    input  logic             cnt_clr
);

    state_e           state_q, state_d;
    logic [7:0]       psw_q;
    cond_flags_t      flags_q;
    logic [7:0]       acc_q;
    cond_e            cond_q;
    logic [PC_W-1:0]  pc_q;
    logic [7:0]       rel_q;
    logic             taken_q;
    logic [PC_W-1:0]  target_q;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             accept;
    logic             eval_taken;
    logic [PC_W-1:0]  fall_pc;
    logic [PC_W-1:0]  eval_target;

    psw_cond_eval u_cond_eval (
        .flags_i (flags_q),
        .acc_i   (acc_q),
        .cond_i  (cond_q),
        .taken_o (eval_taken)
    );

    // Fall-through and relative target both wrap modulo 2^PC_W.
    assign fall_pc     = pc_q + PC_W'(2);
    assign eval_target = eval_taken ? fall_pc + {{(PC_W-8){rel_q[7]}}, rel_q}
                                    : fall_pc;

    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Held low while reset is asserted even though the state is IDLE.
                bus.req_ready = rst_n;
                if (bus.req_valid && rst_n) state_d = ST_EVAL;
            end
            ST_EVAL: state_d = ST_RESP;
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear has priority over increment; both counters stick at all-ones.
    always_comb begin
        req_cnt_d   = req_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (cnt_clr) begin
            req_cnt_d   = '0;
            taken_cnt_d = '0;
        end else begin
            if (accept && (req_cnt_q != '1))
                req_cnt_d = req_cnt_q + CNT_W'(1);
            if ((state_q == ST_EVAL) && eval_taken && (taken_cnt_q != '1))
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every register here uses non-blocking assignment so all of them
    // see pre-edge values of each other, matching the flop hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            psw_q       <= 8'h00;
            flags_q     <= '0;
            acc_q       <= 8'h00;
            cond_q      <= COND_JC;
            pc_q        <= '0;
            rel_q       <= 8'h00;
            taken_q     <= 1'b0;
            target_q    <= '0;
            req_cnt_q   <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            if (psw_load) psw_q <= psw_in;
            if (accept) begin
                // A load in the accept cycle is visible to this request.
                flags_q <= get_cond_flags(psw_load ? psw_in : psw_q);
                acc_q   <= bus.acc_in;
                cond_q  <= cond_e'(bus.cond);
                pc_q    <= bus.pc_in;
                rel_q   <= bus.rel;
            end
            if (state_q == ST_EVAL) begin
                taken_q  <= eval_taken;
                target_q <= eval_target;
            end
        end
    end

    assign bus.taken     = taken_q;
    assign bus.target_pc = target_q;
    assign psw_shadow    = psw_q;
    assign req_cnt       = req_cnt_q;
    assign taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_psw_branch_unit.sv
// Self-checking bench for psw_branch_unit: directed scenarios plus randomized
// requests against a behavioural model of the branch rules.
module tb_psw_branch_unit;

    localparam int PC_W  = 16;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [7:0]       psw_in;
    logic             psw_load;
    logic [7:0]       psw_shadow;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic             cnt_clr;

    psw_branch_unit_if #(.PC_W(PC_W)) bus ();

    psw_branch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .psw_in     (psw_in),
        .psw_load   (psw_load),
        .psw_shadow (psw_shadow),
        .req_cnt    (req_cnt),
        .taken_cnt  (taken_cnt),
        .cnt_clr    (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference state
    logic [7:0] sh_m;
    int         req_m;
    int         taken_m;

    // Branch rules: returns {taken, target}.
    function automatic logic [16:0] ref_branch(input logic [7:0] psw, input logic [7:0] acc,
                                               input logic [2:0] c, input logic [15:0] pc,
                                               input logic [7:0] rel);
        bit t;
        int off, tgt;
        case (c)
            3'd0: t = psw[7];
            3'd1: t = !psw[7];
            3'd2: t = (acc == 0);
            3'd3: t = (acc != 0);
            3'd4: t = psw[2];
            3'd5: t = !psw[2];
            3'd6: t = psw[6];
            default: t = 1;
        endcase
        off = (rel >= 128) ? int'(rel) - 256 : int'(rel);
        tgt = int'(pc) + 2 + (t ? off : 0);
        return {t, 16'(tgt & 32'hFFFF)};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.cond       = 3'd0;
        bus.pc_in      = '0;
        bus.rel        = 8'h00;
        bus.acc_in     = 8'h00;
        psw_in         = 8'h00;
        psw_load       = 1'b0;
        cnt_clr        = 1'b0;
    endtask

    task automatic load_psw(input logic [7:0] v);
        @(negedge clk);
        psw_load = 1'b1;
        psw_in   = v;
        @(posedge clk);
        sh_m = v;
        @(negedge clk);
        psw_load = 1'b0;
        chk_cnt++;
        if (psw_shadow !== v) $display("FAIL load_psw: psw_shadow=%h expected %h", psw_shadow, v);
        else pass_cnt++;
    endtask

    // One full transaction. When use_model is 0, exp_t/exp_tgt are the
    // expected result; otherwise the behavioural model supplies them.
    task automatic run_req(input logic [2:0] c, input logic [15:0] pc, input logic [7:0] rel,
                           input logic [7:0] acc, input bit ld, input logic [7:0] pin,
                           input bit eval_ld, input logic [7:0] eval_pin, input int hold,
                           input bit clr, input bit use_model, input bit exp_t,
                           input logic [15:0] exp_tgt);
        logic [16:0] r;
        bit          et;
        logic [15:0] etgt;
        r    = ref_branch(ld ? pin : sh_m, acc, c, pc, rel);
        et   = use_model ? r[16] : exp_t;
        etgt = use_model ? r[15:0] : exp_tgt;

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.cond      = c;
        bus.pc_in     = pc;
        bus.rel       = rel;
        bus.acc_in    = acc;
        psw_load      = ld;
        psw_in        = pin;
        cnt_clr       = clr;
        chk_cnt++;
        if (bus.req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b expected 1", bus.req_ready);
        else pass_cnt++;

        @(posedge clk);
        if (ld) sh_m = pin;
        if (clr) begin
            req_m   = 0;
            taken_m = 0;
        end else begin
            req_m = sat_inc(req_m);
        end

        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.acc_in    = ~acc;
        psw_load      = eval_ld;
        psw_in        = eval_pin;
        cnt_clr       = 1'b0;
        chk_cnt++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0)
            $display("FAIL eval_cycle: resp_valid=%b req_ready=%b expected 0 0",
                     bus.resp_valid, bus.req_ready);
        else pass_cnt++;

        @(posedge clk);
        if (eval_ld) sh_m = eval_pin;
        if (et) taken_m = sat_inc(taken_m);

        @(negedge clk);
        psw_load = 1'b0;
        chk_cnt++;
        if (bus.resp_valid !== 1'b1 || bus.taken !== et || bus.target_pc !== etgt)
            $display("FAIL resp: valid=%b taken=%b target=%h expected 1 %b %h",
                     bus.resp_valid, bus.taken, bus.target_pc, et, etgt);
        else pass_cnt++;
        chk_cnt++;
        if (psw_shadow !== sh_m || req_cnt !== CNT_W'(req_m) || taken_cnt !== CNT_W'(taken_m))
            $display("FAIL state: shadow=%h req_cnt=%0d taken_cnt=%0d expected %h %0d %0d",
                     psw_shadow, req_cnt, taken_cnt, sh_m, req_m, taken_m);
        else pass_cnt++;

        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.pc_in     = ~pc;
            @(posedge clk);
            @(negedge clk);
            chk_cnt++;
            if (bus.resp_valid !== 1'b1 || bus.taken !== et || bus.target_pc !== etgt ||
                bus.req_ready !== 1'b0 || req_cnt !== CNT_W'(req_m))
                $display("FAIL backpressure: valid=%b taken=%b target=%h ready=%b req_cnt=%0d expected 1 %b %h 0 %0d",
                         bus.resp_valid, bus.taken, bus.target_pc, bus.req_ready, req_cnt,
                         et, etgt, req_m);
            else pass_cnt++;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk_cnt++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL resp_drop: resp_valid=%b req_ready=%b expected 0 1",
                     bus.resp_valid, bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        sh_m = 8'h00; req_m = 0; taken_m = 0;
        #12;
        chk_cnt++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.taken !== 1'b0 ||
            bus.target_pc !== 16'h0 || psw_shadow !== 8'h00 || req_cnt !== '0 || taken_cnt !== '0)
            $display("FAIL reset_outputs: ready=%b valid=%b taken=%b target=%h shadow=%h cnts=%0d/%0d expected all 0",
                     bus.req_ready, bus.resp_valid, bus.taken, bus.target_pc, psw_shadow,
                     req_cnt, taken_cnt);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        load_psw(8'h80);
        run_req(3'd0, 16'h0100, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1'b1, 16'h0112);
        run_req(3'd1, 16'h0100, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1'b0, 16'h0102);
    endtask

    task automatic test_wrap();
        run_req(3'd7, 16'hFFFE, 8'h05, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1'b1, 16'h0005);
        run_req(3'd7, 16'h0100, 8'hFE, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1'b1, 16'h0100);
        run_req(3'd7, 16'h0001, 8'h80, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1'b1, 16'hFF83);
        run_req(3'd2, 16'h0200, 8'h04, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1'b1, 16'h0206);
        run_req(3'd3, 16'h0200, 8'h04, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1'b0, 16'h0202);
    endtask

    task automatic test_backpressure();
        run_req(3'd6, 16'h1234, 8'h7F, 8'h55, 1, 8'h40, 0, 8'h00, 4, 0, 0, 1'b1, 16'h12B5);
    endtask

    task automatic test_coincident_load();
        load_psw(8'h00);
        run_req(3'd4, 16'h0300, 8'h20, 8'h00, 1, 8'h04, 1, 8'h00, 0, 0, 0, 1'b1, 16'h0322);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.cond      = 3'd7;
        bus.pc_in     = 16'h4000;
        bus.rel       = 8'h10;
        psw_load      = 1'b1;
        psw_in        = 8'hC4;
        @(negedge clk);
        bus.req_valid = 1'b0;
        psw_load      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.taken !== 1'b0 ||
            bus.target_pc !== 16'h0 || psw_shadow !== 8'h00 || req_cnt !== '0 || taken_cnt !== '0)
            $display("FAIL reset_mid: ready=%b valid=%b taken=%b target=%h shadow=%h cnts=%0d/%0d expected all 0",
                     bus.req_ready, bus.resp_valid, bus.taken, bus.target_pc, psw_shadow,
                     req_cnt, taken_cnt);
        else pass_cnt++;
        sh_m = 8'h00; req_m = 0; taken_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
                $display("FAIL reset_mid_release[%0d]: resp_valid=%b req_ready=%b expected 0 1",
                         i, bus.resp_valid, bus.req_ready);
            else pass_cnt++;
        end
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_counters();
        for (int i = 0; i < CNT_MAX + 2; i++)
            run_req(3'd7, 16'(i), 8'h01, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1'b0, 16'h0);
        chk_cnt++;
        if (req_cnt !== CNT_W'(CNT_MAX) || taken_cnt !== CNT_W'(CNT_MAX))
            $display("FAIL cnt_saturate: req_cnt=%0d taken_cnt=%0d expected %0d %0d",
                     req_cnt, taken_cnt, CNT_MAX, CNT_MAX);
        else pass_cnt++;
        // Clear coincident with accept: req_cnt 0, taken_cnt then counts this SJMP.
        run_req(3'd7, 16'h0010, 8'h02, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1'b1, 16'h0014);
        chk_cnt++;
        if (req_cnt !== '0 || taken_cnt !== CNT_W'(1))
            $display("FAIL cnt_clr_accept: req_cnt=%0d taken_cnt=%0d expected 0 1", req_cnt, taken_cnt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_req(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                    $urandom_range(0, 2), 0, 1, 1'b0, 16'h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_coincident_load();
        test_reset_mid();
        test_counters();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/psw_branch_unit.md
Name: psw_branch_unit

Overview:
Consumer side of the PSW: reads the flags produced by the ALU add/PSW block and resolves 8051-style conditional relative jumps (JC/JNC/JZ/JNZ/JOV/JNOV/JAC/SJMP).
- Keeps a shadow copy of the PSW, loaded by a strobe.
- Accepts one branch request at a time over a valid/ready handshake.
- Returns taken/not-taken and the resolved 16-bit target PC.
- Keeps saturating request and taken counters for verification visibility.

Parameters:
PC_W, 16, program counter width
CNT_W, 16, width of saturating statistics counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
psw_in  input  8  PSW from ALU flag block (bit7 CY, bit6 AC, bit2 OV, bit0 P)
psw_load  input  1  load psw_in into shadow PSW
acc_in  input  8  accumulator value, sampled at request accept (for JZ/JNZ)
req_valid  input  1  branch request valid
req_ready  output  1  unit can accept a request
cond  input  3  condition code (see Behaviour)
pc_in  input  PC_W  address of the branch instruction
rel  input  8  signed two's-complement relative offset
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
taken  output  1  branch condition true
target_pc  output  PC_W  next PC
psw_shadow  output  8  current shadow PSW
req_cnt  output  CNT_W  accepted requests, saturating
taken_cnt  output  CNT_W  taken branches, saturating
cnt_clr  input  1  synchronous clear of both counters

Behaviour:
Reset (rst_n=0, asynchronous, any state):
- state=IDLE; psw_shadow=0x00, req_ready=0 while asserted then 1 in IDLE.
- resp_valid=0, taken=0, target_pc=0, req_cnt=0, taken_cnt=0.
- An in-flight request is discarded; no response is produced for it.

Shadow PSW:
- psw_shadow<=psw_in on any edge with psw_load=1, in all states.

FSM states IDLE, EVAL, RESP:
- IDLE: req_ready=1. On req_valid&&req_ready, capture cond, acc_in, pc_in and rel, plus a flag snapshot, then go to EVAL.
  - Flag snapshot = psw_in if psw_load is high in the same cycle, else psw_shadow.
- EVAL: req_ready=0. Evaluate the condition from the snapshot and compute target; register taken/target_pc, then go to RESP.
- RESP: resp_valid=1, taken/target_pc held stable. On resp_ready, go to IDLE and drop resp_valid the next cycle.
- Latency: accept at edge N, resp_valid=1 from cycle N+2. Throughput is at most one request per 3 cycles.
- psw_load during EVAL/RESP updates the shadow but not the in-flight result.

Condition codes:
- 0 JC: CY=1
- 1 JNC: CY=0
- 2 JZ: acc==0
- 3 JNZ: acc!=0
- 4 JOV: OV=1
- 5 JNOV: OV=0
- 6 JAC: AC=1
- 7 SJMP: always taken

Target arithmetic:
- fall = pc_in+2, modulo 2^PC_W.
- Taken: target = fall + sign_extend(rel), modulo 2^PC_W (wraps both directions).
- Not taken: target = fall.

Counters:
- req_cnt increments on accept.
- taken_cnt increments on the EVAL->RESP edge when taken=1.
- Both saturate at all-ones.
- cnt_clr wins over a simultaneous increment (result 0).

Decomposition:
- Shared package psw_pkg:
  - PSW bit index constants: CY=7, AC=6, OV=2, P=0.
  - 3-bit condition code constants COND_JC..COND_SJMP.
  - FSM state encoding.
  - The ALU flag block also uses this package.
- One sub-module, psw_cond_eval: combinational (flags snapshot, acc, cond) -> taken.
- Target adder and FSM stay in the top.

Test Plan:
1. psw_load with psw_in=0x80, then request cond=JC, pc=0x0100, rel=0x10 -> resp_valid at N+2, taken=1, target_pc=0x0112; cond=JNC with same inputs -> taken=0, target_pc=0x0102.
2. Wrap and negative offset: SJMP pc=0xFFFE rel=0x05 -> target 0x0005; SJMP pc=0x0100 rel=0xFE -> target 0x0100; JZ acc=0x00 -> taken=1; JNZ acc=0x00 -> taken=0.
3. Backpressure: hold resp_ready=0 for 4 cycles in RESP with req_valid=1 -> resp_valid, taken and target stable; req_ready=0; req_cnt unchanged until IDLE re-accepts.
4. Coincident load: shadow=0x00, accept JOV in the same cycle as psw_load with psw_in=0x04 -> taken=1. A psw_load of 0x00 during EVAL -> result still taken=1, psw_shadow=0x00.
5. Reset mid-operation: assert rst_n=0 in EVAL -> all outputs 0 immediately, no resp_valid after release, req_ready=1 in the first cycle after release.
6. Counters: preload via 0xFFFF taken SJMPs (or force) -> saturate at 0xFFFF; cnt_clr coincident with accept -> req_cnt=0.
